// File: rtl/led_ctrl_pkg.sv
// led_chain_controller shared definitions:
// opcodes, shift FSM state encodings, instruction fields.
package led_ctrl_pkg;

  localparam int OP_HI  = 7;
  localparam int OP_LO  = 3;
  localparam int ARG_HI = 2;
  localparam int ARG_LO = 0;

  typedef enum logic [4:0] {
    OP_NOP     = 5'b00000,
    OP_SET_CH  = 5'b00001,
    OP_SET_ALL = 5'b00010,
    OP_CLEAR   = 5'b00011,
    OP_SHIFT   = 5'b00100,
    OP_GS_EN   = 5'b01000
  } opcode_e;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LOAD    = 4'd1,
    ST_SCLK_LO = 4'd2,
    ST_SCLK_HI = 4'd3,
    ST_LATCH   = 4'd4
  } state_e;

endpackage

// File: rtl/led_gs_timer.sv
// Grayscale PWM timer: gsclk toggles each cycle for 2^GS_W
// rising edges, then blank=1 / gsclk=0 for 2 cycles. Ports: clk, rst_n, gs_en, gsclk, blank.
module led_gs_timer #(
  parameter int GS_W = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic gs_en,
  output logic gsclk,
  output logic blank
);

  localparam int ACT  = 2 * (2 ** GS_W);
  localparam int LAST = ACT + 1;
  localparam int PW   = GS_W + 2;

  // ph counts clk cycles within one PWM period;
  // rising edges of gsclk sit on the even phases below ACT.
  logic [PW-1:0] ph;
  logic [PW-1:0] ph_nxt;
  logic          run;

  always_comb begin
    ph_nxt = '0;
    if (run && ph != PW'(LAST))
      ph_nxt = ph + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      ph    <= '0;
      gsclk <= 1'b0;
      blank <= 1'b1;
    end else if (!gs_en) begin
      run   <= 1'b0;
      ph    <= '0;
      gsclk <= 1'b0;
      blank <= 1'b1;
    end else begin
      run   <= 1'b1;
      ph    <= ph_nxt;
      gsclk <= (ph_nxt < PW'(ACT)) && !ph_nxt[0];
      blank <= ph_nxt >= PW'(ACT);
    end
  end

endmodule

// File: rtl/led_chain_controller.sv
// LED chain controller: grayscale register file, serial shift-out
// FSM (serial/sclk/lat), instruction handshake, GS PWM timer.
module led_chain_controller
  import led_ctrl_pkg::*;
#(
  parameter int N_CH     = 16,
  parameter int GS_W     = 12,
  parameter int SCLK_DIV = 2,
  localparam int AW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      instruction,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [AW-1:0]   ch_addr,
  input  logic [GS_W-1:0] wr_data,
  output logic            serial,
  output logic            sclk,
  output logic            lat,
  output logic            gsclk,
  output logic            blank,
  output logic [3:0]      state
);

  localparam int TOT = N_CH * GS_W;
  localparam int DW  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW  = (TOT > 1) ? $clog2(TOT) : 1;

  logic [GS_W-1:0] regs [N_CH];
  logic [TOT-1:0]  flat;
  logic [TOT-1:0]  sh;
  logic [TOT-1:0]  sh_nxt;
  logic [DW-1:0]   dcnt;
  logic [BW-1:0]   bcnt;
  logic            gs_en;
  logic            ch_ok;
  logic            div_done;
  logic [4:0]      op;
  logic [2:0]      arg;
  logic            unused_arg;
  state_e          st;

  assign op          = instruction[OP_HI:OP_LO];
  assign arg         = instruction[ARG_HI:ARG_LO];
  assign unused_arg  = ^arg[ARG_HI:1];
  assign instr_ready = (st == ST_IDLE);
  assign state       = st;
  assign ch_ok       = 32'(ch_addr) < N_CH;
  assign div_done    = dcnt == DW'(SCLK_DIV - 1);
  assign sh_nxt      = sh << 1;

  // Highest channel lands in the top bits, so it leaves first.
  always_comb begin
    flat = '0;
    for (int c = 0; c < N_CH; c++)
      flat[c*GS_W +: GS_W] = regs[c];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++)
        regs[c] <= '0;
      st     <= ST_IDLE;
      sh     <= '0;
      dcnt   <= '0;
      bcnt   <= '0;
      gs_en  <= 1'b0;
      serial <= 1'b0;
      sclk   <= 1'b0;
      lat    <= 1'b0;
    end else begin
      unique case (st)
        ST_IDLE: begin
          if (instr_valid) begin
            unique case (1'b1)
              op == OP_SET_CH: begin
                if (ch_ok)
                  regs[ch_addr] <= wr_data;
              end
              op == OP_SET_ALL: begin
                for (int c = 0; c < N_CH; c++)
                  regs[c] <= wr_data;
              end
              op == OP_CLEAR: begin
                for (int c = 0; c < N_CH; c++)
                  regs[c] <= '0;
              end
              op == OP_GS_EN: gs_en <= arg[0];
              op == OP_SHIFT: st <= ST_LOAD;
              default: ;
            endcase
          end
        end
        ST_LOAD: begin
          sh     <= flat;
          serial <= flat[TOT-1];
          sclk   <= 1'b0;
          dcnt   <= '0;
          bcnt   <= '0;
          st     <= ST_SCLK_LO;
        end
        ST_SCLK_LO: begin
          if (div_done) begin
            dcnt <= '0;
            sclk <= 1'b1;
            st   <= ST_SCLK_HI;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        ST_SCLK_HI: begin
          if (div_done) begin
            dcnt <= '0;
            sclk <= 1'b0;
            if (bcnt == BW'(TOT - 1)) begin
              serial <= 1'b0;
              lat    <= 1'b1;
              st     <= ST_LATCH;
            end else begin
              // Next bit changes with the sclk fall.
              bcnt   <= bcnt + BW'(1);
              sh     <= sh_nxt;
              serial <= sh_nxt[TOT-1];
              st     <= ST_SCLK_LO;
            end
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        ST_LATCH: begin
          lat    <= 1'b0;
          serial <= 1'b0;
          st     <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  led_gs_timer #(
    .GS_W (GS_W)
  ) u_gs (
    .clk   (clk),
    .rst_n (rst_n),
    .gs_en (gs_en),
    .gsclk (gsclk),
    .blank (blank)
  );

endmodule

// File: tb/tb_led_chain_controller.sv
// Self-checking bench for led_chain_controller
// (N_CH=2, GS_W=4, SCLK_DIV=1): table, corner sequences, random.
module tb_led_chain_controller;

  localparam int N_CH     = 2;
  localparam int GS_W     = 4;
  localparam int SCLK_DIV = 1;
  localparam int TOT      = N_CH * GS_W;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] instruction;
  logic       instr_valid;
  logic       instr_ready;
  logic       ch_addr;
  logic [3:0] wr_data;
  logic       serial;
  logic       sclk;
  logic       lat;
  logic       gsclk;
  logic       blank;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  logic [GS_W-1:0] mdl [N_CH];

  typedef struct {
    logic [4:0]     op;
    logic [2:0]     arg;
    logic           ch;
    logic [3:0]     d;
    logic [TOT-1:0] exp;
  } vec_t;

  vec_t vecs [10];
  bit   g [80];
  bit   b [80];

  led_chain_controller #(
    .N_CH     (N_CH),
    .GS_W     (GS_W),
    .SCLK_DIV (SCLK_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .ch_addr     (ch_addr),
    .wr_data     (wr_data),
    .serial      (serial),
    .sclk        (sclk),
    .lat         (lat),
    .gsclk       (gsclk),
    .blank       (blank),
    .state       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic mdl_apply(input logic [4:0] op,
                           input logic ch,
                           input logic [3:0] d);
    case (op)
      5'd1: mdl[ch] = d;
      5'd2: for (int c = 0; c < N_CH; c++) mdl[c] = d;
      5'd3: for (int c = 0; c < N_CH; c++) mdl[c] = '0;
      default: ;
    endcase
  endtask

  task automatic mdl_clear();
    for (int c = 0; c < N_CH; c++) mdl[c] = '0;
  endtask

  // Highest channel first, MSB first within a channel.
  function automatic logic [TOT-1:0] stream();
    logic [TOT-1:0] s;
    int p;
    s = '0;
    p = TOT - 1;
    for (int c = N_CH - 1; c >= 0; c--)
      for (int k = GS_W - 1; k >= 0; k--) begin
        s[p] = mdl[c][k];
        p--;
      end
    return s;
  endfunction

  task automatic send(input logic [4:0] op,
                      input logic [2:0] arg,
                      input logic ch,
                      input logic [3:0] d);
    int n;
    @(negedge clk);
    instruction = {op, arg};
    ch_addr     = ch;
    wr_data     = d;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout got=0 exp=1");
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    mdl_apply(op, ch, d);
  endtask

  task automatic do_shift(input string nm, input logic [TOT-1:0] exp);
    int rises, latn, latk, rbad;
    logic ps;
    logic [TOT-1:0] got;
    send(5'b00100, 3'b000, 1'b0, 4'h0);
    rises = 0; latn = 0; latk = -1; rbad = 0;
    ps = 1'b0; got = '0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k <= 18 && instr_ready) rbad++;
      if (sclk && !ps) begin
        if (rises < TOT) got[TOT-1-rises] = serial;
        rises++;
      end
      ps = sclk;
      if (lat) begin
        latn++;
        latk = k;
      end
    end
    chk({nm, "_rises"}, rises, TOT);
    chk({nm, "_data"}, got, exp);
    chk({nm, "_latn"}, latn, 1);
    chk({nm, "_latk"}, latk, 18);
    chk({nm, "_busy"}, rbad, 0);
    chk({nm, "_rdy"}, instr_ready, 1);
  endtask

  initial begin
    int n, r, latn, i1, i2, len, gr, ov;
    logic ps;
    logic [4:0] op;

    vecs[0] = '{5'd1, 3'd0, 1'b0, 4'hA, 8'h0A};
    vecs[1] = '{5'd1, 3'd0, 1'b1, 4'h5, 8'h5A};
    vecs[2] = '{5'd2, 3'd0, 1'b0, 4'h3, 8'h33};
    vecs[3] = '{5'd1, 3'd0, 1'b1, 4'hC, 8'hC3};
    vecs[4] = '{5'd3, 3'd0, 1'b0, 4'h7, 8'h00};
    vecs[5] = '{5'd31, 3'd7, 1'b1, 4'h9, 8'h00};
    vecs[6] = '{5'd2, 3'd0, 1'b1, 4'hF, 8'hFF};
    vecs[7] = '{5'd0, 3'd0, 1'b0, 4'h1, 8'hFF};
    vecs[8] = '{5'd8, 3'd0, 1'b0, 4'h2, 8'hFF};
    vecs[9] = '{5'd1, 3'd0, 1'b0, 4'h0, 8'hF0};

    rst_n = 1'b0;
    instruction = '0;
    instr_valid = 1'b0;
    ch_addr = 1'b0;
    wr_data = '0;
    mdl_clear();
    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk, 0);
    chk("rst_lat", lat, 0);
    chk("rst_gsclk", gsclk, 0);
    chk("rst_blank", blank, 1);
    chk("rst_ready", instr_ready, 1);
    chk("rst_state", state, 0);
    chk("rst_serial", serial, 0);
    rst_n = 1'b1;

    // Asynchronous reset asserted mid-cycle
    send(5'd2, 3'd0, 1'b0, 4'h3);
    send(5'd8, 3'd1, 1'b0, 4'h0);
    repeat (5) @(negedge clk);
    send(5'b00100, 3'b000, 1'b0, 4'h0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_sclk", sclk, 0);
    chk("arst_lat", lat, 0);
    chk("arst_gsclk", gsclk, 0);
    chk("arst_blank", blank, 1);
    chk("arst_ready", instr_ready, 1);
    chk("arst_state", state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_clear();
    do_shift("arst_shift", 8'h00);

    // Table-driven instructions, each followed by a shift-out
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].op, vecs[i].arg, vecs[i].ch, vecs[i].d);
      @(negedge clk);
      chk($sformatf("vec%0d_state", i), state, 0);
      chk($sformatf("vec%0d_ready", i), instr_ready, 1);
      chk($sformatf("vec%0d_lat", i), lat, 0);
      do_shift($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Instruction held while busy
    send(5'd1, 3'd0, 1'b1, 4'h0);
    send(5'b00100, 3'b000, 1'b0, 4'h0);
    @(negedge clk);
    instruction = {5'd2, 3'd0};
    wr_data = 4'hF;
    instr_valid = 1'b1;
    chk("stall_ready_busy", instr_ready, 0);
    n = 1;
    while (!instr_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("stall_accept_cycle", n, 19);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    mdl_apply(5'd2, 1'b0, 4'hF);
    do_shift("stall_shift", 8'hFF);

    // GS timer
    send(5'd8, 3'd1, 1'b0, 4'h0);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      g[k] = gsclk;
      b[k] = blank;
    end
    chk("gs_start_gsclk", g[1], 1);
    chk("gs_start_blank", b[1], 0);
    i1 = -1; i2 = -1;
    for (int k = 1; k < 80; k++)
      if (b[k] && !b[k-1]) begin
        if (i1 < 0) i1 = k;
        else if (i2 < 0) i2 = k;
      end
    chk("gs_first_blank", i1, 33);
    chk("gs_period", i2 - i1, 34);
    gr = 0;
    for (int k = 1; k < i1; k++)
      if (g[k] && !g[k-1]) gr++;
    chk("gs_rises", gr, 16);
    len = 0;
    for (int k = (i1 < 0) ? 80 : i1; k < 80 && b[k]; k++) len++;
    chk("gs_blank_len", len, 2);
    ov = 0;
    for (int k = 0; k < 80; k++)
      if (g[k] && b[k]) ov++;
    chk("gs_gated", ov, 0);
    send(5'd8, 3'd0, 1'b0, 4'h0);
    repeat (2) @(negedge clk);
    chk("gs_off_gsclk", gsclk, 0);
    chk("gs_off_blank", blank, 1);

    // Reset after the third sclk rise
    send(5'd8, 3'd1, 1'b0, 4'h0);
    send(5'd2, 3'd0, 1'b0, 4'h9);
    send(5'b00100, 3'b000, 1'b0, 4'h0);
    r = 0; n = 0; ps = 1'b0;
    while (r < 3 && n < 30) begin
      @(negedge clk);
      if (sclk && !ps) r++;
      ps = sclk;
      n++;
    end
    chk("mid_rises", r, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_state", state, 0);
    chk("mid_sclk", sclk, 0);
    chk("mid_lat", lat, 0);
    chk("mid_gsclk", gsclk, 0);
    chk("mid_blank", blank, 1);
    chk("mid_ready", instr_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_clear();
    latn = 0;
    repeat (25) begin
      @(negedge clk);
      if (lat) latn++;
    end
    chk("mid_no_lat", latn, 0);
    chk("mid_idle", state, 0);
    do_shift("mid_shift", 8'h00);

    // Random instructions against the model
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)
        send(5'd1, 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      else if (r == 3)
        send(5'd2, 3'd0, 1'b0, 4'($urandom_range(0, 15)));
      else if (r == 4)
        send(5'd3, 3'd0, 1'b0, 4'($urandom_range(0, 15)));
      else if (r == 5)
        send(5'd0, 3'd0, 1'b1, 4'($urandom_range(0, 15)));
      else if (r == 6) begin
        op = ($urandom_range(0, 1) != 0) ?
             5'($urandom_range(5, 7)) : 5'($urandom_range(9, 31));
        send(op, 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end else
        do_shift($sformatf("rnd%0d", i), stream());
    end
    do_shift("rnd_final", stream());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_chain_controller.md
Name: led_chain_controller

Overview:
- Parametrised successor of the single-chain LED driver controller.
- Holds an N_CH x GS_W grayscale register file and accepts 8-bit instructions under a valid/ready handshake.
- Shifts the register file out MSB-first over serial/sclk with a programmable bit-clock divider, then pulses lat.
- Independently generates gsclk/blank for the grayscale PWM period. Sits between the command source and the external shift-register LED driver chain.

Parameters:
N_CH, 16, number of grayscale channels in the chain
GS_W, 12, grayscale bits per channel
SCLK_DIV, 2, clk cycles per sclk phase (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
instruction  in  8  {opcode[7:3], arg[2:0]}
instr_valid  in  1  instruction present
instr_ready  out  1  controller can accept an instruction
ch_addr  in  $clog2(N_CH)  channel index for SET_CH
wr_data  in  GS_W  grayscale value for SET_CH/SET_ALL
serial  out  1  serial data to driver chain
sclk  out  1  shift clock
lat  out  1  latch pulse
gsclk  out  1  grayscale PWM clock
blank  out  1  PWM blank (1 = LEDs off)
state  out  4  current FSM state encoding

Behaviour:
- Async reset:
  - all channel registers = 0; FSM = IDLE; gs_en = 0.
  - serial = 0, sclk = 0, lat = 0, gsclk = 0, blank = 1, instr_ready = 1, state = 0.
- Handshake: an instruction is accepted on a rising edge with instr_valid && instr_ready. instr_ready = 1 only in IDLE. A valid instruction held while busy is accepted on the first IDLE cycle.
- Opcodes:
  - 00000 NOP.
  - 00001 SET_CH: reg[ch_addr] <= wr_data in the accept cycle; out-of-range ch_addr is ignored.
  - 00010 SET_ALL: all regs <= wr_data.
  - 00011 CLEAR: all regs <= 0.
  - 00100 SHIFT_OUT.
  - 01000 GS_EN: gs_en <= arg[0].
  - Any other opcode is accepted and ignored.
  - All opcodes except SHIFT_OUT complete in the accept cycle; FSM stays IDLE.
- FSM states: IDLE=0, LOAD=1, SCLK_LO=2, SCLK_HI=3, LATCH=4.
  - IDLE -> LOAD on SHIFT_OUT accept.
  - LOAD (1 cycle): snapshot the register file into an N_CH*GS_W shift register. Order is channel N_CH-1 first, MSB first. serial = first bit.
  - SCLK_LO: sclk = 0 for SCLK_DIV cycles -> SCLK_HI.
  - SCLK_HI: sclk = 1 for SCLK_DIV cycles. On exit, the shift register shifts and serial updates while sclk falls. If the last bit was just sent, go to LATCH; otherwise go to SCLK_LO.
  - LATCH: lat = 1 for exactly 1 cycle -> IDLE. serial returns to 0.
  - Busy length = 2 + 2*SCLK_DIV*N_CH*GS_W cycles. sclk produces exactly N_CH*GS_W rising edges. serial is stable across every sclk rising edge.
- Register writes: SET_CH/SET_ALL/CLEAR are impossible during a shift (instr_ready = 0), so shifted data equals the register contents at LOAD.
- GS timer:
  - When gs_en = 1, gsclk toggles every clk cycle. A counter counts gsclk rising edges.
  - After 2^GS_W rising edges: blank = 1 and gsclk is held 0 for 2 cycles, then the counter = 0, blank = 0, and gsclk resumes.
  - Period = 2*2^GS_W + 2 cycles.
  - gs_en = 0: gsclk = 0, blank = 1, counter cleared immediately.
  - The timer runs independently of the shift FSM.
- Reset mid-operation: any state returns to reset values at once. No lat pulse is emitted for an aborted shift.

Decomposition:
- Package led_ctrl_pkg: opcode constants, FSM state encodings (4-bit), instruction field slice positions.
- Sub-module led_gs_timer (params GS_W; ports clk, rst_n, gs_en, gsclk, blank) owns the gsclk/blank counter.
- Shift FSM and register file stay in led_chain_controller.

Test Plan:
Bench parameters: N_CH=2, GS_W=4, SCLK_DIV=1.
1. Reset: assert rst_n=0 mid-cycle -> outputs take reset values immediately: sclk=0, lat=0, gsclk=0, blank=1, instr_ready=1, state=0.
2. Shift-out sequence:
   - Stimulus: SET_CH ch0=4'hA, SET_CH ch1=4'h5, then instruction 8'b00100_000.
   - Serial sampled at sclk rises = 0,1,0,1,1,0,1,0 (8 rises).
   - lat high exactly 1 cycle, 18 cycles after the accept edge; instr_ready low for those 18 cycles.
3. Busy stall: assert SET_ALL wr_data=4'hF during a shift -> held, not accepted until IDLE. A following SHIFT_OUT sends eight 1s.
4. GS timer: GS_EN arg=1 -> 16 gsclk rising edges, then blank=1 for 2 cycles; period 34 cycles. GS_EN arg=0 -> gsclk=0, blank=1 next cycle.
5. Reset mid-shift: deassert rst_n after the 3rd sclk rise -> state=0, no lat pulse. Registers read back 0: a subsequent SHIFT_OUT sends eight 0s.
6. CLEAR, then opcode 11111: CLEAR zeroes the registers; 11111 is accepted in 1 cycle with no output change and state stays 0.
